// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I ADD/SUB/ADDI/LUI into ALU op + operands and
// issues them to the downstream ALU stage through a valid/ready handshake.
// Anything outside that set still issues, as op=ZERO with illegal=1.
// Build option ALU_ISSUE_SKID_EN: when defined, a 2-entry skid buffer with a
// registered in_ready is used; otherwise there is a single output register
// and in_ready is combinational from out_ready.
module alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       op,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [15:0]      issue_count
);

  localparam logic [2:0] OP_ZERO = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;

  localparam logic [6:0] OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  // One issued operation as it sits in an output/skid slot.
  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [4:0]       rd;
    logic             illegal;
  } ent_t;

  ent_t dec;
  ent_t out_q;
  logic out_vld;
  logic in_fire;
  logic out_fire;

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_u;

  assign imm_i = $signed({{20{inst[31]}}, inst[31:20]});
  assign imm_u = $signed({inst[31:12], 12'b0});

  // Decode the offered instruction; illegal encodings issue as an all-zero op.
  always_comb begin
    dec         = '0;
    dec.rd      = inst[11:7];
    dec.illegal = 1'b1;
    case (inst[6:0])
      OPC_REG: begin
        if (inst[14:12] == 3'b000 && inst[31:25] == 7'b0000000) begin
          dec.op      = OP_ADD;
          dec.x       = rs1_val;
          dec.y       = rs2_val;
          dec.illegal = 1'b0;
        end else if (inst[14:12] == 3'b000 && inst[31:25] == 7'b0100000) begin
          dec.op      = OP_SUB;
          dec.x       = rs1_val;
          dec.y       = rs2_val;
          dec.illegal = 1'b0;
        end
      end
      OPC_IMM: begin
        if (inst[14:12] == 3'b000) begin
          dec.op      = OP_ADD;
          dec.x       = rs1_val;
          dec.y       = WIDTH'(imm_i);
          dec.illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec.op      = OP_ADD;
        dec.y       = WIDTH'(imm_u);
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

  assign out_fire = out_vld && out_ready;
  assign in_fire  = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
  ent_t skid_q;
  logic skid_vld;

  // in_ready is the registered "skid slot empty" flag, held low in reset.
  assign in_ready = !skid_vld && !reset;

  // Output slot refills from the skid slot first to keep FIFO order; an input
  // that arrives while the output is stalled parks in the skid slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else if (out_ready || !out_vld) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_q   <= '0;
        skid_vld <= 1'b0;
      end else if (in_fire) begin
        out_q   <= dec;
        out_vld <= 1'b1;
      end else begin
        out_q   <= '0;
        out_vld <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end
`else
  // Accept whenever the single output slot is empty or draining this cycle.
  assign in_ready = !reset && (!out_vld || out_ready);

  // Single output register; cleared to zero whenever it empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (in_fire) begin
      out_q   <= dec;
      out_vld <= 1'b1;
    end else if (out_ready) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end
  end
`endif

  // Count output handshakes, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      issue_count <= '0;
    else if (out_fire && issue_count != 16'hFFFF)
      issue_count <= issue_count + 16'd1;
  end

  assign out_valid = out_vld;
  assign op        = out_q.op;
  assign x         = out_q.x;
  assign y         = out_q.y;
  assign rd        = out_q.rd;
  assign illegal   = out_q.illegal;

endmodule
